// File: rtl/jpeg_bit_packer.sv
// jpeg_bit_packer: concatenates Huffman codes MSB-first into bytes, stuffs 0x00 after
// data 0xFF, pads with 1s on flush and optionally appends the EOI marker.
module jpeg_bit_packer #(
  parameter int unsigned ACC_W    = 32,
  parameter bit          EMIT_EOI = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] code_in,
  input  logic [3:0]  code_len,
  input  logic        code_valid,
  output logic        code_ready,
  input  logic        flush,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic [31:0] byte_count,
  output logic        busy,
  output logic        done
);
  localparam int unsigned FW = $clog2(ACC_W) + 1;

  typedef enum logic [2:0] {PACK, PAD, DRAIN, EOI_FF, EOI_D9, DONE} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [FW-1:0]    fill;

  logic             data_phase;
  logic             take;
  logic             stuff_now;
  logic             load;
  logic [15:0]      len_mask;
  logic [ACC_W-1:0] acc_sh;
  logic [ACC_W-1:0] code_ext;
  logic [ACC_W-1:0] code_place;
  logic [ACC_W-1:0] pad_bits;
  logic [FW-1:0]    fill_sh;
  logic [3:0]       pad_n;

  assign data_phase = (state == PACK) || (state == PAD) || (state == DRAIN);
  assign code_ready = (state == PACK) && (fill <= FW'(ACC_W - 15));
  assign take       = code_valid && code_ready;

  // The 0x00 stuff byte takes the output slot in the same cycle the 0xFF leaves it,
  // which blocks any accumulator byte from overtaking it.
  assign stuff_now  = data_phase && byte_valid && byte_ready && (byte_out == 8'hFF);
  assign load       = data_phase && (!byte_valid || byte_ready) && !stuff_now
                      && (fill >= FW'(8));

  assign acc_sh     = load ? (acc << 8) : acc;
  assign fill_sh    = load ? (fill - FW'(8)) : fill;

  // Valid bits sit left-aligned in acc; new bits go directly below the existing ones.
  assign len_mask   = ~(16'hFFFF << code_len);
  assign code_ext   = {code_in & len_mask, {(ACC_W-16){1'b0}}};
  assign code_place = (code_ext << (5'd16 - {1'b0, code_len})) >> fill_sh;

  assign pad_n      = (fill_sh[2:0] == 3'd0) ? 4'd0 : (4'd8 - {1'b0, fill_sh[2:0]});
  assign pad_bits   = ~({ACC_W{1'b1}} >> pad_n) >> fill_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PACK;
      acc        <= '0;
      fill       <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      byte_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      acc  <= acc_sh;
      fill <= fill_sh;

      if (byte_valid && byte_ready)
        byte_count <= byte_count + 32'd1;

      if (stuff_now) begin
        byte_out   <= 8'h00;
        byte_valid <= 1'b1;
      end else if (load) begin
        byte_out   <= acc[ACC_W-1 -: 8];
        byte_valid <= 1'b1;
      end else if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end

      case (state)
        PACK: begin
          if (take) begin
            acc  <= acc_sh | code_place;
            fill <= fill_sh + FW'(code_len);
            busy <= 1'b1;
          end
          if (flush) begin
            state <= PAD;
            busy  <= 1'b1;
          end
        end
        PAD: begin
          acc   <= acc_sh | pad_bits;
          fill  <= fill_sh + FW'(pad_n);
          state <= DRAIN;
        end
        DRAIN: begin
          if ((fill == '0) && !byte_valid) begin
            if (EMIT_EOI) begin
              byte_out   <= 8'hFF;
              byte_valid <= 1'b1;
              state      <= EOI_FF;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        EOI_FF: begin
          byte_valid <= 1'b1;
          if (byte_ready) begin
            byte_out <= 8'hD9;
            state    <= EOI_D9;
          end
        end
        EOI_D9: begin
          byte_valid <= 1'b1;
          if (byte_ready) begin
            byte_valid <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          byte_count <= '0;
          busy       <= 1'b0;
          state      <= PACK;
        end
        default: state <= PACK;
      endcase
    end
  end
endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Bench for jpeg_bit_packer: table of hand-derived code vectors, expected-byte
// scoreboard, and a bit-level reference model for the backpressure stream.
`timescale 1ns/1ps
module tb_jpeg_bit_packer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] code_in = '0;
  logic [3:0]  code_len = '0;
  logic        code_valid = 1'b0;
  logic        code_ready;
  logic        flush = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic [31:0] byte_count;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];
  bit mbits[$];

  typedef struct {
    logic [15:0] code;
    logic [3:0]  len;
    int          nb;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t vt [0:21];

  jpeg_bit_packer #(.ACC_W(32), .EMIT_EOI(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_len(code_len),
    .code_valid(code_valid), .code_ready(code_ready), .flush(flush),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_count(byte_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sampled mid-cycle, after the driver has settled inputs for the next edge.
  logic       stall_prev = 1'b0;
  logic [7:0] held = '0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", byte_valid, 1);
        check("hold_byte", byte_out, held);
      end
      if (done) done_cnt++;
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", byte_out, 32'h100);
        else check("byte", byte_out, exp_q.pop_front());
      end
      stall_prev = byte_valid && !byte_ready;
      held = byte_out;
    end
  end

  task automatic model_bytes();
    while (mbits.size() >= 8) begin
      logic [7:0] b;
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], mbits.pop_front()};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endtask

  task automatic model_push(input logic [15:0] c, input logic [3:0] l);
    for (int i = int'(l) - 1; i >= 0; i--) mbits.push_back(c[i]);
    model_bytes();
  endtask

  task automatic send(input logic [15:0] c, input logic [3:0] l, input bit use_model);
    int n;
    n = 0;
    code_in = c;
    code_len = l;
    code_valid = 1'b1;
    while (!code_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!code_ready) check("code_ready_timeout", code_ready, 1);
    else if (use_model) model_push(c, l);
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic do_flush(input bit use_model);
    if (use_model) begin
      while (mbits.size() % 8 != 0) mbits.push_back(1'b1);
      model_bytes();
    end
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({name, "_done_pulses"}, done_cnt - d0, 1);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_count_clear"}, byte_count, 0);
    check({name, "_busy_low"}, busy, 0);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_count;
    int n_acc;

    vt[0]  = '{16'h0002, 4'd2,  0, 8'h00, 8'h00};
    vt[1]  = '{16'h0003, 4'd3,  0, 8'h00, 8'h00};
    vt[2]  = '{16'h0007, 4'd3,  1, 8'h9F, 8'h00};
    vt[3]  = '{16'h00FF, 4'd8,  2, 8'hFF, 8'h00};
    vt[4]  = '{16'h007F, 4'd7,  0, 8'h00, 8'h00};
    vt[5]  = '{16'h0001, 4'd1,  2, 8'hFF, 8'h00};
    vt[6]  = '{16'hFFFF, 4'd1,  0, 8'h00, 8'h00};
    vt[7]  = '{16'hFFFF, 4'd0,  0, 8'h00, 8'h00};
    vt[8]  = '{16'h1234, 4'd0,  0, 8'h00, 8'h00};
    for (int i = 9; i < 15; i++) vt[i] = '{16'hFFFE, 4'd1, 0, 8'h00, 8'h00};
    vt[15] = '{16'hFFFE, 4'd1,  1, 8'h80, 8'h00};
    vt[16] = '{16'h7ABC, 4'd15, 1, 8'hF5, 8'h00};
    vt[17] = '{16'h0001, 4'd1,  1, 8'h79, 8'h00};
    vt[18] = '{16'h0005, 4'd3,  0, 8'h00, 8'h00};
    vt[19] = '{16'h001F, 4'd5,  1, 8'hBF, 8'h00};
    vt[20] = '{16'h3FFF, 4'd14, 2, 8'hFF, 8'h00};
    vt[21] = '{16'h0000, 4'd2,  1, 8'hFC, 8'h00};

    #12;
    check("rst_byte_out", byte_out, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_code_ready", code_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven packing, stuffing, masking and zero-length beats
    exp_count = 0;
    for (int i = 0; i < 22; i++) begin
      if (vt[i].nb > 0) exp_q.push_back(vt[i].b0);
      if (vt[i].nb > 1) exp_q.push_back(vt[i].b1);
      exp_count += vt[i].nb;
      send(vt[i].code, vt[i].len, 1'b0);
    end
    wait_empty("table");
    check("table_byte_count", byte_count, exp_count);
    check("table_busy", busy, 1);

    // Three pending bits then flush: pad with 1s and append EOI
    send(16'h0005, 4'd3, 1'b0);
    exp_q.push_back(8'hBF);
    do_flush(1'b0);
    wait_done("eoi");

    // Flush with nothing pending: marker only
    do_flush(1'b0);
    wait_done("empty_flush");

    // Backpressure while 15-bit codes stream
    byte_ready = 1'b0;
    n_acc = 0;
    code_len = 4'd15;
    code_in = 16'($urandom);
    code_valid = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (code_ready) begin
        model_push(code_in, code_len);
        n_acc++;
        @(negedge clk);
        code_in = 16'($urandom);
      end else begin
        @(negedge clk);
      end
    end
    check("bp_code_ready_low", code_ready, 0);
    check("bp_accepts", n_acc, 2);
    check("bp_byte_valid", byte_valid, 1);
    code_valid = 1'b0;
    @(negedge clk);
    byte_ready = 1'b1;
    for (int k = 0; k < 24; k++) send(16'($urandom), 4'($urandom_range(0, 15)), 1'b1);
    do_flush(1'b1);
    wait_done("stream");

    // Reset in the middle of DRAIN with a byte held in the output register
    byte_ready = 1'b0;
    send(16'h7ABC, 4'd15, 1'b0);
    send(16'h1234, 4'd15, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_drain_valid", byte_valid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_byte_out", byte_out, 0);
    check("midrst_byte_valid", byte_valid, 0);
    check("midrst_byte_count", byte_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    exp_q.delete();
    mbits.delete();
    @(negedge clk);
    rst_n = 1'b1;
    byte_ready = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h9F);
    for (int i = 0; i < 3; i++) send(vt[i].code, vt[i].len, 1'b0);
    do_flush(1'b0);
    wait_done("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
